// File: rtl/ram_pkg.sv
// Shared types and helpers for the 1R1W byte-maskable RAM and its zero-fill sequencer.
package ram_pkg;

  typedef enum logic [0:0] {
    READY = 1'b0,
    CLEAR = 1'b1
  } ram_state_e;

  typedef enum logic [0:0] {
    RDW_OLD = 1'b0,
    RDW_NEW = 1'b1
  } rdw_mode_e;

  function automatic int lane_w(input int width, input int lanes);
    return width / lanes;
  endfunction

endpackage

// File: rtl/ram_clear_seq.sv
// Zero-fill sequencer: walks every address once after reset and on request,
// holding the array inaccessible while it runs.
module ram_clear_seq
  import ram_pkg::*;
#(
  parameter int  depth_p     = 512,
  parameter int  init_zero_p = 1,
  localparam int aw          = (depth_p > 1) ? $clog2(depth_p) : 1
) (
  input  logic          clk_i,
  input  logic          reset_ni,
  input  logic          clear_i,
  output logic          ready_o,
  output logic          clear_we,
  output logic [aw-1:0] clear_addr
);

  localparam ram_state_e    reset_state = (init_zero_p != 0) ? CLEAR : READY;
  localparam logic [aw-1:0] last_addr   = aw'(depth_p - 1);

  ram_state_e    state_q;
  logic [aw-1:0] cnt_q;

  // Terminal count is depth_p-1 so non power-of-two depths fill in exactly depth_p cycles.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= reset_state;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        READY: begin
          if (clear_i) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
          end
        end
        CLEAR: begin
          if (cnt_q == last_addr) begin
            state_q <= READY;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + aw'(1);
          end
        end
        default: state_q <= READY;
      endcase
    end
  end

  assign ready_o    = (state_q == READY);
  assign clear_we   = (state_q == CLEAR);
  assign clear_addr = cnt_q;

endmodule

// File: rtl/ram_1r1w_sync_be.sv
// Synchronous 1R1W RAM with per-lane write masks, 1/2-cycle read latency,
// selectable read-during-write policy and a hardware zero-fill sequencer.
module ram_1r1w_sync_be
  import ram_pkg::*;
#(
  parameter int  width_p      = 32,
  parameter int  depth_p      = 512,
  parameter int  lanes_p      = 4,
  parameter int  rd_latency_p = 1,
  parameter int  rdw_mode_p   = 0,
  parameter int  init_zero_p  = 1,
  localparam int aw           = (depth_p > 1) ? $clog2(depth_p) : 1
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  input  logic               clear_i,
  output logic               ready_o,
  input  logic               wr_valid_i,
  input  logic [aw-1:0]      wr_addr_i,
  input  logic [width_p-1:0] wr_data_i,
  input  logic [lanes_p-1:0] wr_mask_i,
  input  logic               rd_valid_i,
  input  logic [aw-1:0]      rd_addr_i,
  output logic               rd_valid_o,
  output logic [width_p-1:0] rd_data_o
);

  localparam int            lw        = lane_w(width_p, lanes_p);
  localparam logic [aw-1:0] last_addr = aw'(depth_p - 1);
  localparam bit            fwd_en    = (rdw_mode_p == int'(RDW_NEW));

  if (width_p % lanes_p != 0) begin : g_bad_lanes
    $error("ram_1r1w_sync_be: width_p must be divisible by lanes_p");
  end
  if (rd_latency_p != 1 && rd_latency_p != 2) begin : g_bad_latency
    $error("ram_1r1w_sync_be: rd_latency_p must be 1 or 2");
  end

  logic          ready;
  logic          clear_we;
  logic [aw-1:0] clear_addr;

  ram_clear_seq #(
    .depth_p     (depth_p),
    .init_zero_p (init_zero_p)
  ) u_clear_seq (
    .clk_i      (clk_i),
    .reset_ni   (reset_ni),
    .clear_i    (clear_i),
    .ready_o    (ready),
    .clear_we   (clear_we),
    .clear_addr (clear_addr)
  );

  assign ready_o = ready;

  logic [width_p-1:0] mem_q [depth_p];
  logic               wr_acc_p0;
  logic               rd_acc_p0;
  logic               rd_in_range;
  logic [width_p-1:0] rd_word_p0;

  assign rd_in_range = (rd_addr_i <= last_addr);
  assign wr_acc_p0   = ready & wr_valid_i & (wr_addr_i <= last_addr);
  assign rd_acc_p0   = ready & rd_valid_i;

  // Stage p0: array update; the fill and user writes are mutually exclusive via ready.
  always_ff @(posedge clk_i) begin
    if (clear_we) begin
      mem_q[clear_addr] <= '0;
    end else if (wr_acc_p0) begin
      for (int k = 0; k < lanes_p; k++) begin
        if (wr_mask_i[k]) mem_q[wr_addr_i][k*lw +: lw] <= wr_data_i[k*lw +: lw];
      end
    end
  end

  always_comb begin
    rd_word_p0 = '0;
    if (rd_in_range) begin
      rd_word_p0 = mem_q[rd_addr_i];
      if (fwd_en && wr_acc_p0 && (wr_addr_i == rd_addr_i)) begin
        for (int k = 0; k < lanes_p; k++) begin
          if (wr_mask_i[k]) rd_word_p0[k*lw +: lw] = wr_data_i[k*lw +: lw];
        end
      end
    end
  end

  if (rd_latency_p == 1) begin : g_lat1
    // Stage p0 -> output: capture at the acceptance edge.
    always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
        rd_valid_o <= 1'b0;
        rd_data_o  <= '0;
      end else begin
        rd_valid_o <= rd_acc_p0;
        if (rd_acc_p0) rd_data_o <= rd_word_p0;
      end
    end
  end else begin : g_lat2
    logic               vld_p1;
    logic [width_p-1:0] data_p1;

    // Stage p1: intermediate register; data only moves with a valid beat.
    always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) vld_p1 <= 1'b0;
      else           vld_p1 <= rd_acc_p0;
    end

    always_ff @(posedge clk_i) begin
      if (rd_acc_p0) data_p1 <= rd_word_p0;
    end

    // Stage p1 -> output.
    always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
        rd_valid_o <= 1'b0;
        rd_data_o  <= '0;
      end else begin
        rd_valid_o <= vld_p1;
        if (vld_p1) rd_data_o <= data_p1;
      end
    end
  end

endmodule

// File: tb/tb_ram_1r1w_sync_be.sv
// Bench: two RAM configurations (1-cycle/old-data and 2-cycle/new-data, depth 300)
// share one stimulus stream; a monitor pops per-instance expectation queues.
module tb_ram_1r1w_sync_be;

  localparam int DEPTH = 300;
  localparam int AW    = 9;

  logic          clk = 1'b0;
  logic          reset_ni;
  logic          clear_i;
  logic          wr_valid_i;
  logic [AW-1:0] wr_addr_i;
  logic [31:0]   wr_data_i;
  logic [3:0]    wr_mask_i;
  logic          rd_valid_i;
  logic [AW-1:0] rd_addr_i;
  logic          ready_a, rd_valid_a, ready_b, rd_valid_b;
  logic [31:0]   rd_data_a, rd_data_b;

  always #5 clk = ~clk;

  ram_1r1w_sync_be #(
    .width_p(32), .depth_p(DEPTH), .lanes_p(4),
    .rd_latency_p(1), .rdw_mode_p(0), .init_zero_p(1)
  ) dut_a (
    .clk_i(clk), .reset_ni(reset_ni), .clear_i(clear_i), .ready_o(ready_a),
    .wr_valid_i(wr_valid_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
    .wr_mask_i(wr_mask_i), .rd_valid_i(rd_valid_i), .rd_addr_i(rd_addr_i),
    .rd_valid_o(rd_valid_a), .rd_data_o(rd_data_a)
  );

  ram_1r1w_sync_be #(
    .width_p(32), .depth_p(DEPTH), .lanes_p(4),
    .rd_latency_p(2), .rdw_mode_p(1), .init_zero_p(1)
  ) dut_b (
    .clk_i(clk), .reset_ni(reset_ni), .clear_i(clear_i), .ready_o(ready_b),
    .wr_valid_i(wr_valid_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
    .wr_mask_i(wr_mask_i), .rd_valid_i(rd_valid_i), .rd_addr_i(rd_addr_i),
    .rd_valid_o(rd_valid_b), .rd_data_o(rd_data_b)
  );

  typedef struct {
    int          due;
    logic [31:0] d;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  bit   exp_ready = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // One cycle of stimulus, applied just after a negedge; reads push expectations.
  task automatic op(input bit wv, input int wa, input logic [31:0] wd, input logic [3:0] wm,
                    input bit rv, input int ra, input logic [31:0] ea, input logic [31:0] eb,
                    input bit clr);
    wr_valid_i = wv;
    wr_addr_i  = wa[AW-1:0];
    wr_data_i  = wd;
    wr_mask_i  = wm;
    rd_valid_i = rv;
    rd_addr_i  = ra[AW-1:0];
    clear_i    = clr;
    if (exp_ready && rv) begin
      qa.push_back('{cyc + 1, ea});
      qb.push_back('{cyc + 2, eb});
    end
    @(negedge clk);
  endtask

  task automatic wr(input int wa, input logic [31:0] wd, input logic [3:0] wm);
    op(1'b1, wa, wd, wm, 1'b0, 0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic rd(input int ra, input logic [31:0] e);
    op(1'b0, 0, 32'h0, 4'h0, 1'b1, ra, e, e, 1'b0);
  endtask

  task automatic idle();
    op(1'b0, 0, 32'h0, 4'h0, 1'b0, 0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic wait_ready(input string nm);
    int n;
    n = 0;
    for (int i = 1; i <= 1000; i++) begin
      @(negedge clk);
      n = i;
      if (ready_a) break;
    end
    chk(n == DEPTH, nm, n, DEPTH);
    chk(ready_b == ready_a, {nm, "_b"}, ready_b, ready_a);
  endtask

  // Monitor: every valid beat must match the head of its queue in data and cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rd_valid_a) begin
        chk(qa.size() != 0, "a_unexpected_valid", qa.size(), 1);
        if (qa.size() != 0) begin
          e = qa.pop_front();
          chk(rd_data_a == e.d, "a_data", rd_data_a, e.d);
          chk(cyc == e.due, "a_latency", cyc, e.due);
        end
      end
      if (rd_valid_b) begin
        chk(qb.size() != 0, "b_unexpected_valid", qb.size(), 1);
        if (qb.size() != 0) begin
          e = qb.pop_front();
          chk(rd_data_b == e.d, "b_data", rd_data_b, e.d);
          chk(cyc == e.due, "b_latency", cyc, e.due);
        end
      end
    end
  end

  initial begin
    int lows;
    reset_ni   = 1'b0;
    clear_i    = 1'b0;
    wr_valid_i = 1'b0;
    wr_addr_i  = '0;
    wr_data_i  = '0;
    wr_mask_i  = '0;
    rd_valid_i = 1'b0;
    rd_addr_i  = '0;
    repeat (3) @(negedge clk);
    chk(ready_a == 1'b0, "reset_ready_a", ready_a, 0);
    chk(ready_b == 1'b0, "reset_ready_b", ready_b, 0);
    chk(rd_valid_a == 1'b0 && rd_valid_b == 1'b0, "reset_rd_valid", {rd_valid_a, rd_valid_b}, 0);
    chk(rd_data_a == 32'h0, "reset_rd_data_a", rd_data_a, 0);
    chk(rd_data_b == 32'h0, "reset_rd_data_b", rd_data_b, 0);

    // Initial fill with traffic that must be ignored.
    reset_ni   = 1'b1;
    wr_valid_i = 1'b1; wr_addr_i = 9'd9; wr_data_i = 32'hFFFF_FFFF; wr_mask_i = 4'hF;
    rd_valid_i = 1'b1; rd_addr_i = 9'd9;
    wait_ready("init_fill_len");
    wr_valid_i = 1'b0;
    rd_valid_i = 1'b0;
    exp_ready  = 1'b1;

    for (int a = 0; a < DEPTH; a++) rd(a, 32'h0);
    rd(310, 32'h0);
    rd(511, 32'h0);

    wr(5, 32'hDEAD_BEEF, 4'b1111);
    wr(5, 32'h1122_3344, 4'b0101);
    rd(5, 32'hDE22_BE44);

    op(1'b1, 7, 32'hAAAA_AAAA, 4'b1111, 1'b1, 7, 32'h0000_0000, 32'hAAAA_AAAA, 1'b0);
    op(1'b1, 7, 32'h5555_5555, 4'b0011, 1'b1, 7, 32'hAAAA_AAAA, 32'hAAAA_5555, 1'b0);
    rd(7, 32'hAAAA_5555);
    wr(7, 32'h0000_0000, 4'b0000);
    rd(7, 32'hAAAA_5555);
    op(1'b1, 8, 32'h1234_5678, 4'b1111, 1'b1, 7, 32'hAAAA_5555, 32'hAAAA_5555, 1'b0);
    rd(8, 32'h1234_5678);
    wr(310, 32'h7777_7777, 4'hF);
    rd(310, 32'h0);

    wr(1, 32'h0101_0101, 4'hF);
    wr(2, 32'h0202_0202, 4'hF);
    wr(3, 32'h0303_0303, 4'hF);
    rd(1, 32'h0101_0101);
    rd(2, 32'h0202_0202);
    rd(3, 32'h0303_0303);
    repeat (4) idle();
    chk(rd_data_a == 32'h0303_0303, "hold_a", rd_data_a, 32'h0303_0303);
    chk(rd_data_b == 32'h0303_0303, "hold_b", rd_data_b, 32'h0303_0303);

    // Clear requested together with a read that must still complete with old data.
    op(1'b0, 0, 32'h0, 4'h0, 1'b1, 1, 32'h0101_0101, 32'h0101_0101, 1'b1);
    exp_ready = 1'b0;
    lows = 0;
    for (int i = 0; i < 1000; i++) begin
      if (ready_a) break;
      lows++;
      clear_i    = (lows == 100);
      wr_valid_i = 1'b1; wr_addr_i = 9'd5; wr_data_i = 32'h1234_5678; wr_mask_i = 4'hF;
      rd_valid_i = 1'b1; rd_addr_i = 9'd5;
      @(negedge clk);
    end
    chk(lows == DEPTH, "clear_len", lows, DEPTH);
    chk(ready_b == ready_a, "clear_ready_b", ready_b, ready_a);
    clear_i    = 1'b0;
    wr_valid_i = 1'b0;
    rd_valid_i = 1'b0;
    exp_ready  = 1'b1;
    rd(5, 32'h0);
    rd(1, 32'h0);
    rd(7, 32'h0);
    rd(8, 32'h0);
    rd(299, 32'h0);
    wr(299, 32'hCAFE_F00D, 4'hF);
    rd(299, 32'hCAFE_F00D);

    // Reset with a read in flight: outputs drop at once, pending beat is flushed.
    rd(299, 32'hCAFE_F00D);
    #1 reset_ni = 1'b0;
    qb.delete();
    exp_ready = 1'b0;
    #1;
    chk(rd_valid_a == 1'b0 && rd_valid_b == 1'b0, "midreset_valid", {rd_valid_a, rd_valid_b}, 0);
    chk(rd_data_a == 32'h0, "midreset_data_a", rd_data_a, 0);
    chk(rd_data_b == 32'h0, "midreset_data_b", rd_data_b, 0);
    repeat (2) @(negedge clk);
    reset_ni = 1'b1;
    repeat (100) @(negedge clk);
    chk(ready_a == 1'b0, "midfill_ready", ready_a, 0);
    #1 reset_ni = 1'b0;
    repeat (2) @(negedge clk);
    reset_ni = 1'b1;
    wait_ready("refill_len");
    exp_ready = 1'b1;
    rd(299, 32'h0);
    rd(5, 32'h0);
    rd(310, 32'h0);

    repeat (4) idle();
    chk(qa.size() == 0, "drain_a", qa.size(), 0);
    chk(qb.size() == 0, "drain_b", qb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_1r1w_sync_be.md
Name: ram_1r1w_sync_be

Overview:
Next-generation synchronous 1-read/1-write RAM for the sorting datapath.
- Adds per-lane write masks and a selectable 1- or 2-cycle read latency with a rd_valid_o flag.
- Adds a selectable read-during-write policy.
- Adds a hardware zero-fill sequencer that runs after reset and on request.
- Serves as buffer storage between sort stages, where bulk clearing between passes is required.

Parameters:
- width_p, 32, data word width in bits; must be divisible by lanes_p.
- depth_p, 512, number of words; need not be a power of two.
- lanes_p, 4, number of independently writable lanes; lane width = width_p/lanes_p.
- rd_latency_p, 1, read latency in cycles; legal values are 1 or 2.
- rdw_mode_p, 0, same-address read-during-write policy: 0 = old data, 1 = new (forwarded) data.
- init_zero_p, 1, 1 = zero-fill the whole array after reset deasserts.

Ports:
- clk_i  in  1  clock.
- reset_ni  in  1  asynchronous active-low reset.
- clear_i  in  1  request zero-fill of the whole array.
- ready_o  out  1  1 = array accessible; 0 = zero-fill in progress.
- wr_valid_i  in  1  write enable.
- wr_addr_i  in  $clog2(depth_p)  write address.
- wr_data_i  in  width_p  write data.
- wr_mask_i  in  lanes_p  per-lane write enable; bit k covers data bits [(k+1)*lw-1 : k*lw].
- rd_valid_i  in  1  read request.
- rd_addr_i  in  $clog2(depth_p)  read address.
- rd_valid_o  out  1  rd_data_o carries the result of a read accepted rd_latency_p cycles earlier.
- rd_data_o  out  width_p  read data; holds its last value between reads.

Behaviour:
- Address width: aw = max(1, $clog2(depth_p)).
- Elaboration error if width_p % lanes_p != 0 or rd_latency_p is not 1 or 2.
- Reset (reset_ni = 0, asynchronous):
  - rd_valid_o = 0, rd_data_o = 0, read pipeline flushed.
  - ready_o = 0 if init_zero_p = 1, else 1.
  - Array contents are not reset.
- FSM states: READY and CLEAR.
  - Reset exit goes to CLEAR if init_zero_p = 1, else READY.
  - READY & clear_i -> CLEAR on the next edge.
  - CLEAR writes 0 to address cnt each cycle, cnt running 0..depth_p-1, so the fill takes exactly depth_p cycles.
  - After the write to depth_p-1 the FSM returns to READY and ready_o = 1 in the following cycle.
  - The counter terminates at depth_p-1, not 2^aw-1.
  - clear_i during CLEAR is ignored; the fill does not restart.
- During CLEAR:
  - wr_valid_i and rd_valid_i are ignored: no write, no read accepted.
  - No new rd_valid_o pulses are produced; reads accepted before CLEAR still complete and use pre-clear data captured at acceptance.
- Reset asserted mid-CLEAR aborts the fill. Contents are undefined until the fill that follows reset completes (init_zero_p = 1).
- Write: a write is accepted when ready_o & wr_valid_i. Only lanes with wr_mask_i[k] = 1 are updated, at the clock edge. A mask of all zeros is a no-op.
- Read: a read is accepted when ready_o & rd_valid_i. The array is sampled at the acceptance edge.
  - rd_latency_p = 1: rd_data_o and rd_valid_o update at the acceptance edge.
  - rd_latency_p = 2: one extra output register stage is added. Back-to-back reads give one result per cycle.
- Same-address read and write accepted in the same cycle:
  - rdw_mode_p = 0: the read returns pre-write data.
  - rdw_mode_p = 1: the read returns masked lanes from wr_data_i and unmasked lanes from the array.
- Addresses >= depth_p: writes are dropped; reads return 0 with rd_valid_o asserted normally.
- rd_valid_o is a single-cycle pulse per accepted read. rd_data_o is not cleared when rd_valid_o = 0.

Decomposition:
- Package ram_pkg holds:
  - ram_state_e {READY, CLEAR}.
  - rdw_mode_e {RDW_OLD = 0, RDW_NEW = 1}.
  - Function lane_w(width, lanes) for lane width.
- Sub-module ram_clear_seq (FSM plus address counter) produces ready_o, clear_we and clear_addr.
- The top level contains the array, the write/clear mux, read forwarding and the latency pipeline.

Test Plan:
- Reset release with init_zero_p = 1, depth_p = 512 -> ready_o goes high exactly 512 cycles later. Read of every address returns 0x00000000.
- Write 0xDEADBEEF to address 5 with mask 4'b1111, then 0x11223344 to address 5 with mask 4'b0101 -> read of address 5 returns 0xDE22BE44.
- Same-cycle write of 0xAAAAAAAA and read of address 7 (old value 0x0) -> rdw_mode_p = 0 returns 0x0; rdw_mode_p = 1 returns 0xAAAAAAAA.
- rd_latency_p = 2 with reads of addresses 1, 2, 3 on consecutive cycles -> rd_valid_o high on cycles +2, +3, +4 with the matching data, and rd_data_o held afterward.
- clear_i pulsed at cycle 100 of traffic -> ready_o = 0 for depth_p cycles; concurrent writes are dropped; all reads after the fill return 0. A second clear_i pulse mid-fill does not extend the fill.
- depth_p = 300: read of address 310 -> returns 0 with rd_valid_o asserted. Reset asserted mid-fill -> rd_valid_o = 0 immediately, and the fill restarts from address 0 after release.
